// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader and fetch side.
package imem_loader_pkg;

    localparam int unsigned ADDR_WIDTH     = 16;
    localparam int unsigned INST_WIDTH     = 32;
    localparam int unsigned IMEMORY_SIZE   = 1024;
    localparam int unsigned BYTES_PER_WORD = INST_WIDTH / 8;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StWrite,
        StDone
    } load_state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Collects bytes little-endian into one instruction word; flags the byte that completes it.
module imem_word_assembler
    import imem_loader_pkg::*;
#(
    parameter int unsigned NumBytes = BYTES_PER_WORD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic [8*NumBytes-1:0] word_data,
    output logic                  word_complete
);

    localparam int unsigned IdxW = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

    logic [IdxW-1:0]       idx_q, idx_d;
    logic [8*NumBytes-1:0] word_q, word_d;

    // Next byte index and partial word; byte k lands in bits [8k+7:8k].
    always_comb begin
        idx_d         = idx_q;
        word_d        = word_q;
        word_complete = byte_valid && (idx_q == LastIdx);
        if (clear) begin
            idx_d = '0;
        end else if (byte_valid) begin
            word_d[8*idx_q +: 8] = byte_data;
            idx_d                = word_complete ? '0 : idx_q + 1'b1;
        end
    end

    // Index and partial-word registers; reset discards any half-built word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_data = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a program byte stream into imem, holding the CPU off until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_count,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [INST_WIDTH-1:0] wr_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    // Bound compared one bit wider than the address so an overflowing increment never wraps low.
    localparam logic [ADDR_WIDTH:0] MemSize = (ADDR_WIDTH + 1)'(IMEMORY_SIZE);

    load_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remain_q, remain_d;
    logic                  error_q, error_d;

    logic                  byte_accept;
    logic                  word_complete;
    logic [INST_WIDTH-1:0] word_data;
    logic [ADDR_WIDTH:0]   next_addr;

    assign byte_accept = (state_q == StRecv) && in_valid;
    assign next_addr   = {1'b0, addr_q} + 1'b1;

    imem_word_assembler #(
        .NumBytes(BYTES_PER_WORD)
    ) u_assembler (
        .clk          (clk),
        .reset        (reset),
        .clear        (state_q != StRecv),
        .byte_valid   (byte_accept),
        .byte_data    (in_data),
        .word_data    (word_data),
        .word_complete(word_complete)
    );

    // Next-state, address/count and error-flag logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        error_d  = error_q;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    error_d  = 1'b0;
                    addr_d   = load_base;
                    remain_d = load_count;
                    if (load_count == '0) begin
                        state_d = StDone;
                    end else if ({1'b0, load_base} >= MemSize) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = StRecv;
                    end
                end
            end
            StRecv: begin
                if (word_complete) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                addr_d   = next_addr[ADDR_WIDTH-1:0];
                remain_d = remain_q - 1'b1;
                if (remain_q == (ADDR_WIDTH + 1)'(1)) begin
                    state_d = StDone;
                end else if (next_addr >= MemSize) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StRecv;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, address, remaining-count and sticky-error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            remain_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            error_q  <= error_d;
        end
    end

    // All outputs decode registered state only, so in_ready has no path from in_valid.
    assign in_ready   = (state_q == StRecv);
    assign wr_en      = (state_q == StWrite);
    assign wr_addr    = addr_q;
    assign wr_data    = word_data;
    assign cpu_hold   = (state_q != StIdle);
    assign load_done  = (state_q == StDone);
    assign load_error = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load scenarios plus a mid-load reset sequence.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  load_start;
    logic [ADDR_WIDTH-1:0] load_base;
    logic [ADDR_WIDTH:0]   load_count;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [INST_WIDTH-1:0] wr_data;
    logic                  cpu_hold;
    logic                  load_done;
    logic                  load_error;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .load_start(load_start),
        .load_base (load_base),
        .load_count(load_count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_error(load_error)
    );

    typedef struct {
        logic [15:0] base;
        logic [16:0] count;
        logic [95:0] stream;       // byte k at [8k+7:8k]
        int          nbytes;       // bytes the source offers
        bit          toggle;       // in_valid only on odd cycles
        int          spur;         // cycle of a stray load_start (0 = none)
        int          exp_nw;
        logic [47:0] exp_addr;     // write i address at [16i+15:16i]
        logic [95:0] exp_data;     // write i data at [32i+31:32i]
        int          exp_ndone;
        int          exp_done_cyc;
        bit          exp_err;
        int          exp_hold;     // cycles cpu_hold is high after the start edge
        int          exp_bytes;    // bytes accepted
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_load(input vec_t v, input int id);
        int  bi = 0;
        int  nw = 0;
        int  ndone = 0;
        int  done_cyc = 0;
        int  hold = 0;
        bit  ended = 0;
        @(posedge clk); #1;
        load_start = 1'b1;
        load_base  = v.base;
        load_count = v.count;
        in_valid   = 1'b0;
        @(posedge clk); #1;
        load_start = 1'b0;
        load_base  = '1;
        load_count = '1;
        for (int c = 1; c <= 100; c++) begin
            if (!cpu_hold) begin
                ended = 1;
                break;
            end
            hold++;
            if (wr_en) begin
                if (nw < v.exp_nw) begin
                    check($sformatf("v%0d wr_addr%0d", id, nw), 64'(wr_addr),
                          64'(v.exp_addr[nw*16 +: 16]));
                    check($sformatf("v%0d wr_data%0d", id, nw), 64'(wr_data),
                          64'(v.exp_data[nw*32 +: 32]));
                end
                nw++;
            end
            if (load_done) begin
                ndone++;
                done_cyc = c;
            end
            load_start = (c == v.spur);
            if (c == v.spur) begin
                load_base  = 16'h0200;
                load_count = 17'd3;
            end
            in_valid = (!v.toggle || (c % 2 == 1)) && (bi < v.nbytes);
            in_data  = (bi < 12) ? v.stream[bi*8 +: 8] : 8'h00;
            if (in_ready && in_valid) bi++;
            @(posedge clk); #1;
        end
        in_valid   = 1'b0;
        load_start = 1'b0;
        check($sformatf("v%0d finished", id), 64'(ended), 64'd1);
        check($sformatf("v%0d writes", id), 64'(nw), 64'(v.exp_nw));
        check($sformatf("v%0d done pulses", id), 64'(ndone), 64'(v.exp_ndone));
        if (v.exp_ndone > 0)
            check($sformatf("v%0d done cycle", id), 64'(done_cyc), 64'(v.exp_done_cyc));
        check($sformatf("v%0d hold cycles", id), 64'(hold), 64'(v.exp_hold));
        check($sformatf("v%0d bytes accepted", id), 64'(bi), 64'(v.exp_bytes));
        check($sformatf("v%0d load_error", id), 64'(load_error), 64'(v.exp_err));
        check($sformatf("v%0d in_ready idle", id), 64'(in_ready), 64'd0);
        check($sformatf("v%0d wr_en idle", id), 64'(wr_en), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " in_ready"}, 64'(in_ready), 64'd0);
        check({tag, " wr_en"}, 64'(wr_en), 64'd0);
        check({tag, " wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, " wr_data"}, 64'(wr_data), 64'd0);
        check({tag, " cpu_hold"}, 64'(cpu_hold), 64'd0);
        check({tag, " load_done"}, 64'(load_done), 64'd0);
        check({tag, " load_error"}, 64'(load_error), 64'd0);
    endtask

    initial begin
        // base, count, stream, nbytes, toggle, spur, nw, addr, data, ndone, done_cyc, err, hold, bytes
        vecs[0] = '{16'd0, 17'd2, 96'h00000000_DEADBEEF_12345678, 8, 1'b0, 0,
                    2, 48'h0000_0001_0000, 96'h00000000_DEADBEEF_12345678, 1, 11, 1'b0, 11, 8};
        vecs[1] = '{16'd0, 17'd2, 96'h00000000_DEADBEEF_12345678, 8, 1'b1, 0,
                    2, 48'h0000_0001_0000, 96'h00000000_DEADBEEF_12345678, 1, 17, 1'b0, 17, 8};
        vecs[2] = '{16'd1022, 17'd3, 96'hCCBBAA99_88776655_44332211, 12, 1'b0, 0,
                    2, 48'h0000_03FF_03FE, 96'h00000000_88776655_44332211, 0, 0, 1'b1, 10, 8};
        vecs[3] = '{16'd7, 17'd0, 96'h0, 0, 1'b0, 0,
                    0, 48'h0, 96'h0, 1, 1, 1'b0, 1, 0};
        vecs[4] = '{16'd1024, 17'd1, 96'h00000000_00000000_44332211, 4, 1'b0, 0,
                    0, 48'h0, 96'h0, 0, 0, 1'b1, 0, 0};
        vecs[5] = '{16'd16, 17'd1, 96'h00000000_00000000_D4C3B2A1, 4, 1'b0, 2,
                    1, 48'h0000_0000_0010, 96'h00000000_00000000_D4C3B2A1, 1, 6, 1'b0, 6, 4};
        vecs[6] = '{16'd5, 17'd1, 96'h00000000_00000000_04030201, 4, 1'b0, 0,
                    1, 48'h0000_0000_0005, 96'h00000000_00000000_04030201, 1, 6, 1'b0, 6, 4};

        reset      = 1'b1;
        load_start = 1'b0;
        load_base  = '0;
        load_count = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        #12;
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_load(vecs[i], i);

        // Reset arriving after two bytes of word 1 must drop the partial word at once.
        @(posedge clk); #1;
        load_start = 1'b1;
        load_base  = 16'd0;
        load_count = 17'd2;
        @(posedge clk); #1;
        load_start = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h5A;
        repeat (7) @(posedge clk);
        #1;
        check("midload in_ready", 64'(in_ready), 64'd1);
        check("midload cpu_hold", 64'(cpu_hold), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async reset");
        in_valid = 1'b0;
        #2 reset = 1'b0;
        run_load(vecs[6], 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
